// File: rtl/kd_tree_node.sv
// One node of a systolic k-d tree: holds a center point and split axis, fills children and routes points.
// Optional per-cycle trace printing is enabled by defining KD_TREE_NODE_TRACE_EN.
module kd_tree_node #(
  parameter int DIM     = 3,
  parameter int COORD_W = 8,
  parameter int CMD_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DIM*COORD_W-1:0]   data_from_top,
  input  logic [DIM*COORD_W-1:0]   data_from_left,
  input  logic [DIM*COORD_W-1:0]   data_from_right,
  input  logic [CMD_W-1:0]         command_from_top,
  input  logic [CMD_W-1:0]         command_from_left,
  input  logic [CMD_W-1:0]         command_from_right,
  output logic [DIM*COORD_W-1:0]   data_to_top,
  output logic [DIM*COORD_W-1:0]   data_to_left,
  output logic [DIM*COORD_W-1:0]   data_to_right,
  output logic [CMD_W-1:0]         command_to_top,
  output logic [CMD_W-1:0]         command_to_left,
  output logic [CMD_W-1:0]         command_to_right
);
  localparam int DATA_W = DIM * COORD_W;
  localparam int AXIS_W = 2;

  localparam logic [CMD_W-1:0] NOP         = CMD_W'(5'b00000);
  localparam logic [CMD_W-1:0] CENTER_FILL = CMD_W'(5'b00001);
  localparam logic [CMD_W-1:0] CFG_AXIS    = CMD_W'(5'b00010);
  localparam logic [CMD_W-1:0] ROUTE_POINT = CMD_W'(5'b01001);
  localparam logic [CMD_W-1:0] FILL_ACK    = CMD_W'(5'b00101);
  localparam logic [CMD_W-1:0] FILL_FULL   = CMD_W'(5'b01101);
  localparam logic [CMD_W-1:0] CFG_DONE    = CMD_W'(5'b00111);
  localparam logic [CMD_W-1:0] ROUTE_DONE  = CMD_W'(5'b01010);
  localparam logic [CMD_W-1:0] BUSY        = CMD_W'(5'b01000);
  localparam logic [CMD_W-1:0] DNE         = CMD_W'(5'b10000);

  localparam logic [AXIS_W-1:0] AX_MAX = AXIS_W'(DIM - 1);

  typedef enum logic [2:0] {IDLE, FILL_FWD, CFG_WAIT, ROUTE_WAIT, RESP, WAIT_NOP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   center_q, center_d;
  logic                valid_q, valid_d;
  logic [AXIS_W-1:0]   axis_q, axis_d;
  logic                lfull_q, lfull_d, rfull_q, rfull_d;
  logic                fwd_r_q, fwd_r_d;
  logic                cfg_l_q, cfg_l_d, cfg_r_q, cfg_r_d;
  logic [DATA_W-1:0]   dtop_q, dtop_d, dleft_q, dleft_d, dright_q, dright_d;
  logic [CMD_W-1:0]    ctop_q, ctop_d, cleft_q, cleft_d, cright_q, cright_d;

  logic                l_abs, r_abs, l_full_eff, r_full_eff;
  logic [AXIS_W-1:0]   ax_in, ax_sat, ax_nxt;
  logic [COORD_W-1:0]  p_coord, c_coord;
  logic                go_right;
  logic [CMD_W-1:0]    fwd_reply;

  always_comb begin
    l_abs      = (command_from_left == DNE);
    r_abs      = (command_from_right == DNE);
    l_full_eff = lfull_q | l_abs;
    r_full_eff = rfull_q | r_abs;
    ax_in      = data_from_top[AXIS_W-1:0];
    ax_sat     = (ax_in > AX_MAX) ? AX_MAX : ax_in;
    ax_nxt     = (ax_sat == AX_MAX) ? '0 : ax_sat + 1'b1;
    p_coord    = data_from_top[axis_q*COORD_W +: COORD_W];
    c_coord    = center_q[axis_q*COORD_W +: COORD_W];
    go_right   = !(p_coord < c_coord);
    fwd_reply  = fwd_r_q ? command_from_right : command_from_left;
  end

  always_comb begin
    state_d  = state_q;
    center_d = center_q;
    valid_d  = valid_q;
    axis_d   = axis_q;
    lfull_d  = lfull_q;
    rfull_d  = rfull_q;
    fwd_r_d  = fwd_r_q;
    cfg_l_d  = cfg_l_q;
    cfg_r_d  = cfg_r_q;
    dtop_d   = dtop_q;
    dleft_d  = dleft_q;
    dright_d = dright_q;
    ctop_d   = NOP;
    cleft_d  = cleft_q;
    cright_d = cright_q;
    case (state_q)
      IDLE: begin
        case (command_from_top)
          CENTER_FILL: begin
            if (!valid_q) begin
              center_d = data_from_top;
              valid_d  = 1'b1;
              state_d  = RESP;
              ctop_d   = FILL_ACK;
            end else if (!l_full_eff) begin
              dleft_d = data_from_top;
              cleft_d = CENTER_FILL;
              fwd_r_d = 1'b0;
              state_d = FILL_FWD;
            end else if (!r_full_eff) begin
              dright_d = data_from_top;
              cright_d = CENTER_FILL;
              fwd_r_d  = 1'b1;
              state_d  = FILL_FWD;
            end else begin
              state_d = RESP;
              ctop_d  = FILL_FULL;
            end
          end
          CFG_AXIS: begin
            axis_d  = ax_sat;
            cfg_l_d = l_abs;
            cfg_r_d = r_abs;
            if (!l_abs) begin
              dleft_d = DATA_W'(ax_nxt);
              cleft_d = CFG_AXIS;
            end
            if (!r_abs) begin
              dright_d = DATA_W'(ax_nxt);
              cright_d = CFG_AXIS;
            end
            if (l_abs && r_abs) begin
              state_d = RESP;
              ctop_d  = CFG_DONE;
            end else begin
              state_d = CFG_WAIT;
            end
          end
          ROUTE_POINT: begin
            if (!valid_q) begin
              dtop_d  = '0;
              state_d = RESP;
              ctop_d  = ROUTE_DONE;
            end else if (go_right && !r_abs) begin
              dright_d = data_from_top;
              cright_d = ROUTE_POINT;
              fwd_r_d  = 1'b1;
              state_d  = ROUTE_WAIT;
            end else if (!go_right && !l_abs) begin
              dleft_d = data_from_top;
              cleft_d = ROUTE_POINT;
              fwd_r_d = 1'b0;
              state_d = ROUTE_WAIT;
            end else begin
              dtop_d  = center_q;
              state_d = RESP;
              ctop_d  = ROUTE_DONE;
            end
          end
          default: ;
        endcase
      end
      FILL_FWD: begin
        if (fwd_reply == FILL_ACK) begin
          if (fwd_r_q) cright_d = NOP;
          else         cleft_d  = NOP;
          state_d = RESP;
          ctop_d  = FILL_ACK;
        end else if (fwd_reply == FILL_FULL) begin
          if (fwd_r_q) begin
            rfull_d  = 1'b1;
            cright_d = NOP;
            state_d  = RESP;
            ctop_d   = FILL_FULL;
          end else begin
            lfull_d = 1'b1;
            cleft_d = NOP;
            // Left is exhausted; offer the same word to the right subtree.
            if (!r_full_eff) begin
              dright_d = dleft_q;
              cright_d = CENTER_FILL;
              fwd_r_d  = 1'b1;
            end else begin
              state_d = RESP;
              ctop_d  = FILL_FULL;
            end
          end
        end
      end
      CFG_WAIT: begin
        if (!cfg_l_q && command_from_left == CFG_DONE) begin
          cfg_l_d = 1'b1;
          cleft_d = NOP;
        end
        if (!cfg_r_q && command_from_right == CFG_DONE) begin
          cfg_r_d  = 1'b1;
          cright_d = NOP;
        end
        if (cfg_l_d && cfg_r_d) begin
          state_d = RESP;
          ctop_d  = CFG_DONE;
        end
      end
      ROUTE_WAIT: begin
        if (fwd_reply == ROUTE_DONE) begin
          dtop_d = fwd_r_q ? data_from_right : data_from_left;
          if (fwd_r_q) cright_d = NOP;
          else         cleft_d  = NOP;
          state_d = RESP;
          ctop_d  = ROUTE_DONE;
        end
      end
      RESP:     state_d = WAIT_NOP;
      WAIT_NOP: if (command_from_top == NOP) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_d == FILL_FWD || state_d == CFG_WAIT || state_d == ROUTE_WAIT) ctop_d = BUSY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      center_q <= '0;
      valid_q  <= 1'b0;
      axis_q   <= '0;
      lfull_q  <= 1'b0;
      rfull_q  <= 1'b0;
      fwd_r_q  <= 1'b0;
      cfg_l_q  <= 1'b0;
      cfg_r_q  <= 1'b0;
      dtop_q   <= '0;
      dleft_q  <= '0;
      dright_q <= '0;
      ctop_q   <= NOP;
      cleft_q  <= NOP;
      cright_q <= NOP;
    end else begin
      state_q  <= state_d;
      center_q <= center_d;
      valid_q  <= valid_d;
      axis_q   <= axis_d;
      lfull_q  <= lfull_d;
      rfull_q  <= rfull_d;
      fwd_r_q  <= fwd_r_d;
      cfg_l_q  <= cfg_l_d;
      cfg_r_q  <= cfg_r_d;
      dtop_q   <= dtop_d;
      dleft_q  <= dleft_d;
      dright_q <= dright_d;
      ctop_q   <= ctop_d;
      cleft_q  <= cleft_d;
      cright_q <= cright_d;
    end
  end

  assign data_to_top      = dtop_q;
  assign data_to_left     = dleft_q;
  assign data_to_right    = dright_q;
  assign command_to_top   = ctop_q;
  assign command_to_left  = cleft_q;
  assign command_to_right = cright_q;

`ifdef KD_TREE_NODE_TRACE_EN
  always_ff @(posedge clk) begin
    $display("%m st=%0d ctr=%h v=%b ax=%0d | ct=%h cl=%h cr=%h -> ct=%h cl=%h cr=%h | dt=%h dl=%h dr=%h -> dt=%h dl=%h dr=%h",
             state_q, center_q, valid_q, axis_q,
             command_from_top, command_from_left, command_from_right, ctop_q, cleft_q, cright_q,
             data_from_top, data_from_left, data_from_right, dtop_q, dleft_q, dright_q);
  end
`else
  // Trace disabled: no display logic is elaborated.
`endif

endmodule

// File: doc/kd_tree_node.md
KD_TREE_NODE -- requirements
Module: kd_tree_node

Interface
REQ-001 Parameter DIM, default 3, number of coordinates per point (2..4).
REQ-002 Parameter COORD_W, default 8, bits per coordinate.
REQ-003 Parameter CMD_W, default 5, command width; DATA_W = DIM*COORD_W, AXIS_W = 2 (localparams).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 data_from_top/left/right  input  DATA_W each  point/center words from parent and children; coordinate k at bits [k*COORD_W +: COORD_W].
REQ-007 command_from_top/left/right  input  CMD_W each  commands from parent and child replies.
REQ-008 data_to_top/left/right  output reg  DATA_W each  registered data to parent/children.
REQ-009 command_to_top/left/right  output reg  CMD_W each  registered commands/replies.
REQ-010 Encodings: NOP 00000, CENTER_FILL 00001, CFG_AXIS 00010, ROUTE_POINT 01001, FILL_ACK 00101, FILL_FULL 01101, CFG_DONE 00111, ROUTE_DONE 01010, BUSY 01000, DNE 10000 (child absent, driven constant by tie-off).

Function
REQ-011 FSM states: IDLE, FILL_FWD, CFG_WAIT, ROUTE_WAIT, RESP, WAIT_NOP.
REQ-012 IDLE accepts a top command only when command_from_top != NOP; command_to_top = BUSY in every state except IDLE, RESP, WAIT_NOP.
REQ-013 Child absent iff its command_from_* == DNE; absent child counts as full and is never forwarded to.
REQ-014 CENTER_FILL, center not valid: latch data_from_top into center, set valid, RESP with FILL_ACK (reply 1 cycle after acceptance).
REQ-015 CENTER_FILL, center valid: forward to left if left_full clear, else right if right_full clear; drive child data/CENTER_FILL registered, enter FILL_FWD.
REQ-016 FILL_FWD: child FILL_ACK -> drop child command to NOP, RESP FILL_ACK; child FILL_FULL -> set that child's full flag, retry next child same word; none left -> RESP FILL_FULL.
REQ-017 CENTER_FILL with valid center and both children full -> RESP FILL_FULL directly; no state change.
REQ-018 CFG_AXIS: latch data_from_top[AXIS_W-1:0] as axis; send (axis+1) mod DIM to both present children with CFG_AXIS; CFG_WAIT until each present child returns CFG_DONE (latched, any order, possibly different cycles); then RESP CFG_DONE. Axis >= DIM saturates to DIM-1.
REQ-019 ROUTE_POINT: compare unsigned point[axis] with center[axis]; strictly less -> left, else right; chosen child present -> forward, ROUTE_WAIT; absent -> RESP ROUTE_DONE, data_to_top = center.
REQ-020 ROUTE_WAIT: child ROUTE_DONE -> copy child data to data_to_top, RESP ROUTE_DONE.
REQ-021 ROUTE_POINT with center not valid -> RESP ROUTE_DONE, data_to_top = 0.
REQ-022 RESP drives reply exactly one cycle, then WAIT_NOP; WAIT_NOP returns to IDLE on first cycle command_from_top == NOP (no re-execution of held command).
REQ-023 Children commands return to NOP the cycle after their reply is consumed; unexpected child replies ignored.
REQ-024 Unknown top commands ignored in IDLE.

Reset
REQ-025 rst_n low at clk edge: state IDLE, center 0, valid 0, axis 0, full flags 0, all data_to_* 0, all command_to_* NOP; overrides any in-flight operation, no reply issued.

Configuration
REQ-026 Macro KD_TREE_NODE_TRACE_EN defined: per-cycle $display of node state, center, axis, all commands/data; undefined: no display code, identical RTL function.

Verification
REQ-027 Single node both children DNE, CENTER_FILL 0x102030 -> FILL_ACK at cycle+1, center 0x102030; second CENTER_FILL -> FILL_FULL.
REQ-028 3-node tree, fill 0x505050, 0x202020, 0x808080, then 4th word -> ACK, ACK(left), ACK(right), FILL_FULL; left center 0x202020.
REQ-029 CFG_AXIS data 2, DIM=3 -> children receive 0, CFG_DONE after both child replies; data 3 -> axis 2.
REQ-030 Root axis 0, center 0x505050, point 0x000050 (coord0=0x50) -> routed right (equal goes right), ROUTE_DONE carries right child's center.
REQ-031 rst_n low during ROUTE_WAIT -> next cycle all outputs NOP/0, state IDLE, no ROUTE_DONE.
REQ-032 Top holds ROUTE_POINT 5 cycles after reply -> exactly one ROUTE_DONE pulse, no re-route until NOP seen.
